// File: rtl/adv_init_seq.sv
// ADV7513 register initialisation sequencer.
//
// Steps through a fixed 12-entry {register, value} table and issues one
// I2C write per entry to an external byte-oriented I2C master. Each write
// is acknowledged through I2C_Done/I2C_Ack_Err. A NACK or a missing
// I2C_Done within TIMEOUT_CYCLES aborts the sequence. A new rising edge on
// Start reruns the table from entry 0, for example after a hot-plug.
//
// Optional feature: define ADV_INIT_RETRY_EN to re-issue a failed entry up
// to 3 times before aborting. The retry count restarts for each entry.
//
// Parameters:
//   DEV_ADDR        8-bit device write address driven on I2C_Addr
//   GAP_CYCLES      idle cycles between consecutive writes (0 = no gap)
//   TIMEOUT_CYCLES  WAIT cycles allowed before a write is declared failed
//
// Ports:
//   Clock        in   rising-edge clock (i2c_clk domain)
//   Reset_n      in   asynchronous active-low reset
//   Start        in   sequence request; only its rising edge is used
//   I2C_Busy     in   I2C master transfer in progress
//   I2C_Done     in   one-cycle pulse, current transfer finished
//   I2C_Ack_Err  in   valid with I2C_Done, 1 = slave NACK
//   I2C_Start    out  one-cycle transfer request
//   I2C_Addr     out  device address
//   I2C_Reg      out  register address of the current write
//   I2C_Data     out  value of the current write
//   Busy         out  sequence running
//   Done         out  sticky, all entries written without error
//   Error        out  sticky, sequence aborted
//   Index        out  current table entry, 0..11

module adv_init_seq #(
    parameter logic [7:0]  DEV_ADDR       = 8'h72,
    parameter int unsigned GAP_CYCLES     = 4,
    parameter logic [19:0] TIMEOUT_CYCLES = 20'd100000
) (
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic       Start,
    input  logic       I2C_Busy,
    input  logic       I2C_Done,
    input  logic       I2C_Ack_Err,
    output logic       I2C_Start,
    output logic [7:0] I2C_Addr,
    output logic [7:0] I2C_Reg,
    output logic [7:0] I2C_Data,
    output logic       Busy,
    output logic       Done,
    output logic       Error,
    output logic [3:0] Index
);

    localparam logic [3:0]  LAST_INDEX = 4'd11;
    // Terminal counts; a zero timeout behaves like a timeout of one cycle.
    localparam logic [19:0] TO_LAST    = (TIMEOUT_CYCLES == 20'd0) ? 20'd0
                                                                   : TIMEOUT_CYCLES - 20'd1;
    localparam logic [15:0] GAP_LAST   = (GAP_CYCLES == 0) ? 16'd0 : 16'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StGap,
        StDone,
        StErr
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  index_q, index_d;
    logic        start_prev_q;
    logic        i2c_start_q, i2c_start_d;
    logic [7:0]  reg_q, reg_d;
    logic [7:0]  data_q, data_d;
    logic [19:0] to_cnt_q, to_cnt_d;
    logic [15:0] gap_cnt_q, gap_cnt_d;
`ifdef ADV_INIT_RETRY_EN
    logic [1:0]  retry_q, retry_d;
`endif

    logic       start_rise;
    logic       write_fail;
    logic       entry_ok;
    logic [7:0] tbl_reg;
    logic [7:0] tbl_data;

    assign start_rise = Start & ~start_prev_q;
    assign write_fail = I2C_Done ? I2C_Ack_Err : (to_cnt_q == TO_LAST);

    always_comb begin
        tbl_reg  = 8'h00;
        tbl_data = 8'h00;
        case (index_q)
            4'd0:    begin tbl_reg = 8'h41; tbl_data = 8'h10; end
            4'd1:    begin tbl_reg = 8'h98; tbl_data = 8'h03; end
            4'd2:    begin tbl_reg = 8'h9A; tbl_data = 8'hE0; end
            4'd3:    begin tbl_reg = 8'h9C; tbl_data = 8'h30; end
            4'd4:    begin tbl_reg = 8'h9D; tbl_data = 8'h61; end
            4'd5:    begin tbl_reg = 8'hA2; tbl_data = 8'hA4; end
            4'd6:    begin tbl_reg = 8'hA3; tbl_data = 8'hA4; end
            4'd7:    begin tbl_reg = 8'hE0; tbl_data = 8'hD0; end
            4'd8:    begin tbl_reg = 8'hF9; tbl_data = 8'h00; end
            4'd9:    begin tbl_reg = 8'h15; tbl_data = 8'h00; end
            4'd10:   begin tbl_reg = 8'h16; tbl_data = 8'h30; end
            4'd11:   begin tbl_reg = 8'hD6; tbl_data = 8'hC0; end
            default: begin tbl_reg = 8'h00; tbl_data = 8'h00; end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        i2c_start_d = 1'b0;
        reg_d       = reg_q;
        data_d      = data_q;
        to_cnt_d    = to_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        entry_ok    = 1'b0;
`ifdef ADV_INIT_RETRY_EN
        retry_d     = retry_q;
`endif

        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (start_rise) begin
                    state_d = StIssue;
                    index_d = 4'd0;
`ifdef ADV_INIT_RETRY_EN
                    retry_d = 2'd0;
`endif
                end
            end
            StIssue: begin
                // Address/data are latched with the request and held until
                // the next issue, so they stay stable through I2C_Done.
                if (!I2C_Busy) begin
                    i2c_start_d = 1'b1;
                    reg_d       = tbl_reg;
                    data_d      = tbl_data;
                    to_cnt_d    = 20'd0;
                    state_d     = StWait;
                end
            end
            StWait: begin
                if (I2C_Done && !I2C_Ack_Err) begin
                    if (GAP_CYCLES == 0) begin
                        entry_ok = 1'b1;
                    end else begin
                        gap_cnt_d = 16'd0;
                        state_d   = StGap;
                    end
                end else if (write_fail) begin
`ifdef ADV_INIT_RETRY_EN
                    if (retry_q != 2'd3) begin
                        retry_d = retry_q + 2'd1;
                        state_d = StIssue;
                    end else begin
                        state_d = StErr;
                    end
`else
                    state_d = StErr;
`endif
                end else begin
                    to_cnt_d = to_cnt_q + 20'd1;
                end
            end
            StGap: begin
                if (gap_cnt_q == GAP_LAST) begin
                    entry_ok = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (entry_ok) begin
`ifdef ADV_INIT_RETRY_EN
            retry_d = 2'd0;
`endif
            if (index_q == LAST_INDEX) begin
                state_d = StDone;
            end else begin
                index_d = index_q + 4'd1;
                state_d = StIssue;
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= StIdle;
            index_q      <= 4'd0;
            // Primed high so a Start already asserted at release is not an edge.
            start_prev_q <= 1'b1;
            i2c_start_q  <= 1'b0;
            reg_q        <= 8'h00;
            data_q       <= 8'h00;
            to_cnt_q     <= 20'd0;
            gap_cnt_q    <= 16'd0;
`ifdef ADV_INIT_RETRY_EN
            retry_q      <= 2'd0;
`endif
        end else begin
            state_q      <= state_d;
            index_q      <= index_d;
            start_prev_q <= Start;
            i2c_start_q  <= i2c_start_d;
            reg_q        <= reg_d;
            data_q       <= data_d;
            to_cnt_q     <= to_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
`ifdef ADV_INIT_RETRY_EN
            retry_q      <= retry_d;
`endif
        end
    end

    assign I2C_Start = i2c_start_q;
    assign I2C_Addr  = DEV_ADDR;
    assign I2C_Reg   = reg_q;
    assign I2C_Data  = data_q;
    assign Busy      = (state_q == StIssue) || (state_q == StWait) || (state_q == StGap);
    assign Done      = (state_q == StDone);
    assign Error     = (state_q == StErr);
    assign Index     = index_q;

endmodule

// File: doc/adv_init_seq.md
ADV_INIT_SEQ -- requirements
Module: adv_init_seq

Interface
REQ-001 Parameter DEV_ADDR, default 8'h72, 8-bit ADV7513 write address driven on I2C_Addr.
REQ-002 Parameter GAP_CYCLES, default 4, idle cycles between consecutive register writes; 0 is legal (no gap).
REQ-003 Parameter TIMEOUT_CYCLES, default 20'd100000, max cycles in WAIT before the write is declared failed.
REQ-004 Clock  in  1  single clock, rising edge; the i2c_clk domain.
REQ-005 Reset_n  in  1  asynchronous active-low reset.
REQ-006 Start  in  1  request to run the sequence; rising edge detected internally.
REQ-007 I2C_Busy  in  1  I2C master transfer in progress.
REQ-008 I2C_Done  in  1  one-cycle pulse; current transfer finished.
REQ-009 I2C_Ack_Err  in  1  qualified by I2C_Done; 1 = slave NACK.
REQ-010 I2C_Start  out  1  one-cycle transfer request to the I2C master.
REQ-011 I2C_Addr / I2C_Reg / I2C_Data  out  8 each  device address, register, value.
REQ-012 Busy  out  1  sequence running.
REQ-013 Done  out  1  sticky; all entries written without error.
REQ-014 Error  out  1  sticky; sequence aborted.
REQ-015 Index  out  4  current table entry, 0..11.

Function
REQ-016 Fixed 12-entry table {reg,data}, written in order: 41/10, 98/03, 9A/E0, 9C/30, 9D/61, A2/A4, A3/A4, E0/D0, F9/00, 15/00, 16/30, D6/C0.
REQ-017 States: IDLE, ISSUE, WAIT, GAP, DONE, ERR.
REQ-018 IDLE: Start rising edge -> ISSUE; Index <= 0; Done and Error cleared the same cycle.
REQ-019 ISSUE: while I2C_Busy=1, stall; else pulse I2C_Start exactly one cycle with Reg/Data = table[Index], then -> WAIT.
REQ-020 I2C_Addr/Reg/Data stay stable from the I2C_Start cycle until I2C_Done.
REQ-021 WAIT: I2C_Done with Ack_Err=0 -> GAP; with Ack_Err=1 -> ERR; counter reaching TIMEOUT_CYCLES with no Done -> ERR.
REQ-022 GAP: wait GAP_CYCLES cycles; then Index=11 -> DONE, else Index+1 -> ISSUE.
REQ-023 DONE/ERR: set Done or Error; Busy=0; a new Start rising edge restarts from Index 0 (re-initialisation after hot-plug).
REQ-024 Start edges while Busy=1 are ignored; Start held high does not retrigger.
REQ-025 I2C_Done outside WAIT is ignored.
REQ-026 Busy = 1 in ISSUE, WAIT and GAP only.
REQ-027 Done and Error are never both 1.

Reset
REQ-028 Reset_n low: state IDLE, Index 0, I2C_Start 0, I2C_Reg/I2C_Data 0, Busy/Done/Error 0, counters 0, edge detector primed so a Start already held high at release does not trigger.
REQ-029 Reset mid-transfer aborts immediately; no further I2C_Start until a new Start edge.

Configuration
REQ-030 Macro ADV_INIT_RETRY_EN defined: NACK or timeout re-issues the same entry, up to 3 retries per entry (counter reset per entry), then ERR.
REQ-031 Macro ADV_INIT_RETRY_EN undefined: first NACK or timeout -> ERR; no retry counter logic present.

Verification
REQ-032 Start pulse, I2C model ACKs every write after 10 cycles -> 12 I2C_Start pulses, reg/data pairs match REQ-016 in order, Done=1, Error=0.
REQ-033 NACK on entry 3 (9C), macro undefined -> Error=1, Index=3, exactly 4 I2C_Start pulses total.
REQ-034 NACK twice on entry 3, macro defined -> entry 3 issued 3 times, sequence completes, Done=1, 14 pulses total.
REQ-035 I2C_Done withheld on entry 0 -> Error=1 exactly TIMEOUT_CYCLES cycles after entering WAIT; no I2C_Start during the wait.
REQ-036 Reset_n low during entry 6 WAIT, then released with Start held high -> all outputs 0, no I2C_Start until Start toggles low->high, then sequence runs from entry 0.
REQ-037 I2C_Busy held high 50 cycles at ISSUE, spurious Start edge mid-sequence -> I2C_Start delayed until Busy=0, exactly one pulse per entry, sequence unaffected.
